pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle/pipelined CPU datapath, replacing the fixed 32-bit PC register.
Holds the PC and computes the next PC every cycle: sequential, conditional branch, absolute jump, call and return.
Contains a circular return-address stack (RAS) and a redirect-flush counter that tells the fetch/decode stages to squash wrong-path instructions.
Stall hold is supported.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 0, PC value loaded on reset.
INST_BYTES, 4, sequential increment; power of two, >= 1.
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2.
FLUSH_CYCLES, 2, cycles Flush stays high after a redirect; >= 1.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Stall  input  1  1 = hold PC and RAS this cycle.
PC_Change  input  1  1 = control-flow instruction; Mode is valid.
Mode  input  2  00 BRANCH, 01 JUMP, 10 CALL, 11 RETURN.
Branch  input  1  branch-taken condition; used only in BRANCH mode.
Target  input  XLEN  absolute target address; for RETURN it is the fallback used when the RAS is empty.
PCout  output  XLEN  current PC (registered).
Flush  output  1  high while wrong-path instructions must be squashed.
RAS_Empty  output  1  RAS count == 0.
RAS_Full  output  1  RAS count == RAS_DEPTH.
RAS_Error  output  1  sticky; set on push-when-full or pop-when-empty.

Behaviour:
- Reset (asynchronous, any time, including mid-flush or mid-stall):
  - PCout = RESET_VECTOR, RAS count = 0 and pointer = 0, Flush = 0, flush counter = 0, RAS_Error = 0.
  - RAS entry contents are don't-care.
- All updates occur on the rising edge of Clock while Reset = 0. PCout changes one cycle after the selecting inputs.
- Sequential value seq = PCout + INST_BYTES, modulo 2^XLEN (wraps from all-ones to 0 with no flag).
- Alignment: targets are aligned by forcing the low log2(INST_BYTES) bits to 0. Both Target and the popped RAS value are aligned.
- Next-PC selection when Stall = 0:
  - PC_Change = 0: PCout <= seq.
  - BRANCH: Branch = 1 -> aligned Target (redirect); Branch = 0 -> seq.
  - JUMP: aligned Target (redirect).
  - CALL: aligned Target (redirect); push seq onto the RAS.
  - RETURN, RAS non-empty: top of stack (redirect); pop.
  - RETURN, RAS empty: aligned Target (redirect); set RAS_Error; count stays 0.
- RAS:
  - Circular buffer; push writes at the pointer, then increments the pointer.
  - Push when full overwrites the oldest entry, count stays RAS_DEPTH, RAS_Error is set.
  - Pop reads entry pointer-1 and decrements the pointer.
  - Push and pop never occur in the same cycle, since Mode is single-valued.
- Redirect means any selected value that is not seq. A redirect whose target happens to equal seq still counts as a redirect.
- Flush:
  - On a redirect the flush counter loads FLUSH_CYCLES; Flush = (counter != 0), registered.
  - Flush rises in the same cycle PCout takes the new target.
  - The counter decrements by 1 per cycle, and decrements even during Stall.
  - A new redirect while Flush is high reloads the counter to FLUSH_CYCLES.
- Stall = 1:
  - PCout, RAS and RAS_Error hold; PC_Change, Mode and Branch are ignored, so no redirect occurs.
  - The flush countdown continues.
- RAS_Error clears only on Reset.

Test Plan:
1. Reset with RESET_VECTOR = 0x100, then 3 cycles with PC_Change = 0 -> PCout 0x100, 0x104, 0x108, 0x10C; Flush = 0; RAS_Empty = 1.
2. PCout = 0x200, BRANCH with Branch = 0 -> 0x204, Flush stays 0. Then BRANCH with Branch = 1, Target = 0x403 -> PCout = 0x400, Flush high for exactly 2 cycles.
3. CALL Target = 0x800 at PC 0x10 -> PC 0x800, RAS holds 0x14. Next cycle RETURN -> PC 0x14, RAS_Empty = 1, RAS_Error = 0.
4. With RAS_DEPTH = 4, five CALLs from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> RAS_Full = 1, RAS_Error = 1. Five RETURNs then yield 0x404, 0x304, 0x204, 0x104, then the Target fallback with RAS_Empty.
5. Stall held 3 cycles during a JUMP request -> PCout unchanged and no redirect; an in-progress Flush still counts down to 0.
6. PCout = 0xFFFFFFFC with XLEN = 32 and sequential flow -> PCout = 0x0. Asserting Reset mid-flush -> Flush = 0 and PCout = RESET_VECTOR immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_if.sv
// Control-flow request bundle between the fetch/decode control logic and the PC unit.
// master: drives Stall/PC_Change/Mode/Branch/Target, observes PC and RAS/flush status.
// slave : the PC unit itself.
interface pc_if #(
  parameter int unsigned XLEN = 32
);
  logic            Stall;
  logic            PC_Change;
  logic [1:0]      Mode;
  logic            Branch;
  logic [XLEN-1:0] Target;
  logic [XLEN-1:0] PCout;
  logic            Flush;
  logic            RAS_Empty;
  logic            RAS_Full;
  logic            RAS_Error;

  modport master (
    output Stall, PC_Change, Mode, Branch, Target,
    input  PCout, Flush, RAS_Empty, RAS_Full, RAS_Error
  );

  modport slave (
    input  Stall, PC_Change, Mode, Branch, Target,
    output PCout, Flush, RAS_Empty, RAS_Full, RAS_Error
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, selects sequential / branch / jump / call /
// return successors, keeps a circular return-address stack and raises Flush for
// FLUSH_CYCLES cycles after every redirect.
// Ports: Clock, Reset (async, active-high), bus (pc_if.slave): Stall, PC_Change,
// Mode, Branch, Target in; PCout, Flush, RAS_Empty, RAS_Full, RAS_Error out.
module pc_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned    INST_BYTES   = 4,
  parameter int unsigned    RAS_DEPTH    = 4,
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input  logic Clock,
  input  logic Reset,
  pc_if.slave  bus
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INST_BYTES) - XLEN'(1));

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_JUMP   = 2'b01,
    MODE_CALL   = 2'b10,
    MODE_RETURN = 2'b11
  } mode_e;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             err_q, err_d;
  logic             flush_q, empty_q, full_q;
  logic [XLEN-1:0]  seq_c;
  logic             push_c;
  logic             redirect_c;

  // Next-PC selection, RAS bookkeeping and flush countdown
  always_comb begin
    seq_c      = pc_q + XLEN'(INST_BYTES);
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    push_c     = 1'b0;
    redirect_c = 1'b0;

    if (!bus.Stall) begin
      pc_d = seq_c;
      if (bus.PC_Change) begin
        unique case (mode_e'(bus.Mode))
          MODE_BRANCH: begin
            if (bus.Branch) begin
              pc_d       = bus.Target & ALIGN_MASK;
              redirect_c = 1'b1;
            end
          end
          MODE_JUMP: begin
            pc_d       = bus.Target & ALIGN_MASK;
            redirect_c = 1'b1;
          end
          MODE_CALL: begin
            pc_d       = bus.Target & ALIGN_MASK;
            redirect_c = 1'b1;
            push_c     = 1'b1;
            ptr_d      = ptr_q + PTR_W'(1);
            // Full stack: the write at ptr lands on the oldest entry
            if (cnt_q == CNT_W'(RAS_DEPTH)) err_d = 1'b1;
            else                            cnt_d = cnt_q + CNT_W'(1);
          end
          MODE_RETURN: begin
            redirect_c = 1'b1;
            if (cnt_q == '0) begin
              pc_d  = bus.Target & ALIGN_MASK;
              err_d = 1'b1;
            end else begin
              pc_d  = ras_q[ptr_q - PTR_W'(1)] & ALIGN_MASK;
              ptr_d = ptr_q - PTR_W'(1);
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        endcase
      end
    end

    // Countdown runs even while stalled; a redirect reloads it
    if (redirect_c)        fcnt_d = FC_W'(FLUSH_CYCLES);
    else if (fcnt_q != '0) fcnt_d = fcnt_q - FC_W'(1);
    else                   fcnt_d = fcnt_q;
  end

  // Architectural state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_VECTOR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
      flush_q <= (fcnt_d != '0);
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
    end
  end

  // RAS storage; contents are not reset
  always_ff @(posedge Clock) begin
    if (push_c && !Reset) ras_q[ptr_q] <= seq_c;
  end

  assign bus.PCout     = pc_q;
  assign bus.Flush     = flush_q;
  assign bus.RAS_Empty = empty_q;
  assign bus.RAS_Full  = full_q;
  assign bus.RAS_Error = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam logic [31:0] RV = 32'h100;
  localparam logic [1:0] M_BR = 2'b00, M_JMP = 2'b01, M_CALL = 2'b10, M_RET = 2'b11;

  logic Clock;
  logic Reset;
  pc_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .INST_BYTES(4), .RAS_DEPTH(4), .FLUSH_CYCLES(2)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model: PC, return stack as a queue (oldest at front), flush cycles left
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_err;
  int          m_flush;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_ras.delete();
    m_err   = 0;
    m_flush = 0;
  endtask

  task automatic model_step();
    logic [31:0] seq;
    logic [31:0] nxt;
    bit          redir;
    seq   = m_pc + 32'd4;
    nxt   = seq;
    redir = 0;
    if (!bus.Stall) begin
      if (bus.PC_Change) begin
        case (bus.Mode)
          M_BR: if (bus.Branch) begin nxt = align(bus.Target); redir = 1; end
          M_JMP: begin nxt = align(bus.Target); redir = 1; end
          M_CALL: begin
            nxt = align(bus.Target); redir = 1;
            if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_err = 1; end
            m_ras.push_back(seq);
          end
          default: begin
            redir = 1;
            if (m_ras.size() == 0) begin nxt = align(bus.Target); m_err = 1; end
            else nxt = align(m_ras.pop_back());
          end
        endcase
      end
      m_pc = nxt;
    end
    if (redir) m_flush = 2;
    else if (m_flush > 0) m_flush--;
  endtask

  // Every-cycle comparison against the model
  always @(negedge Clock) begin
    if (chk_en && !Reset) begin
      check("pc",    bus.PCout, m_pc);
      check("flush", 32'(bus.Flush), 32'(m_flush > 0));
      check("empty", 32'(bus.RAS_Empty), 32'(m_ras.size() == 0));
      check("full",  32'(bus.RAS_Full), 32'(m_ras.size() == 4));
      check("error", 32'(bus.RAS_Error), 32'(m_err));
    end
  end

  task automatic cyc(input bit st, input bit chg, input logic [1:0] md,
                     input bit br, input logic [31:0] tg);
    bus.Stall = st; bus.PC_Change = chg; bus.Mode = md; bus.Branch = br; bus.Target = tg;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, M_BR, 0, 32'h0);
  endtask

  // Asynchronous reset between clock edges; outputs must change immediately
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_pc",    bus.PCout, RV);
    check("rst_flush", 32'(bus.Flush), 32'd0);
    check("rst_empty", 32'(bus.RAS_Empty), 32'd1);
    check("rst_err",   32'(bus.RAS_Error), 32'd0);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Stall = 0; bus.PC_Change = 0; bus.Mode = M_BR; bus.Branch = 0; bus.Target = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    #1;
    check("init_pc", bus.PCout, 32'h100);
    check("init_flush", 32'(bus.Flush), 32'd0);
    Reset = 1'b0;
    chk_en = 1;

    // Sequential flow from the reset vector
    idle(); idle(); idle();
    check("seq3_pc", bus.PCout, 32'h10C);
    check("seq3_empty", 32'(bus.RAS_Empty), 32'd1);

    // Branch not taken / taken with misaligned target
    cyc(0, 1, M_JMP, 0, 32'h200);
    cyc(1, 0, M_BR, 0, 0); cyc(1, 0, M_BR, 0, 0);
    cyc(0, 1, M_BR, 0, 32'h999);
    check("bnt_pc", bus.PCout, 32'h204);
    check("bnt_flush", 32'(bus.Flush), 32'd0);
    cyc(0, 1, M_BR, 1, 32'h403);
    check("bt_pc", bus.PCout, 32'h400);
    check("bt_flush1", 32'(bus.Flush), 32'd1);
    idle();
    check("bt_flush2", 32'(bus.Flush), 32'd1);
    idle();
    check("bt_flush3", 32'(bus.Flush), 32'd0);

    // Call / return pair
    cyc(0, 1, M_JMP, 0, 32'h10);
    cyc(0, 1, M_CALL, 0, 32'h800);
    check("call_pc", bus.PCout, 32'h800);
    cyc(0, 1, M_RET, 0, 32'h0);
    check("ret_pc", bus.PCout, 32'h14);
    check("ret_empty", 32'(bus.RAS_Empty), 32'd1);
    check("ret_err", 32'(bus.RAS_Error), 32'd0);

    // Overfill the stack, then drain past empty
    cyc(0, 1, M_JMP, 0, 32'h0);
    cyc(0, 1, M_CALL, 0, 32'h100);
    cyc(0, 1, M_CALL, 0, 32'h200);
    cyc(0, 1, M_CALL, 0, 32'h300);
    cyc(0, 1, M_CALL, 0, 32'h400);
    check("ovf_err0", 32'(bus.RAS_Error), 32'd0);
    cyc(0, 1, M_CALL, 0, 32'h500);
    check("ovf_full", 32'(bus.RAS_Full), 32'd1);
    check("ovf_err", 32'(bus.RAS_Error), 32'd1);
    cyc(0, 1, M_RET, 0, 32'h0); check("pop1", bus.PCout, 32'h404);
    cyc(0, 1, M_RET, 0, 32'h0); check("pop2", bus.PCout, 32'h304);
    cyc(0, 1, M_RET, 0, 32'h0); check("pop3", bus.PCout, 32'h204);
    cyc(0, 1, M_RET, 0, 32'h0); check("pop4", bus.PCout, 32'h104);
    cyc(0, 1, M_RET, 0, 32'h602);
    check("pop5_fallback", bus.PCout, 32'h600);
    check("pop5_empty", 32'(bus.RAS_Empty), 32'd1);

    // Stall ignores a jump request while the flush countdown continues
    cyc(0, 1, M_JMP, 0, 32'h1000);
    cyc(1, 1, M_JMP, 0, 32'h2000);
    check("stall1_pc", bus.PCout, 32'h1000);
    check("stall1_flush", 32'(bus.Flush), 32'd1);
    cyc(1, 1, M_JMP, 0, 32'h2000);
    check("stall2_flush", 32'(bus.Flush), 32'd0);
    cyc(1, 1, M_JMP, 0, 32'h2000);
    check("stall3_pc", bus.PCout, 32'h1000);
    check("stall3_flush", 32'(bus.Flush), 32'd0);

    // Address wrap, then reset in the middle of a flush
    cyc(0, 1, M_JMP, 0, 32'hFFFF_FFFC);
    idle();
    check("wrap_pc", bus.PCout, 32'h0);
    cyc(0, 1, M_JMP, 0, 32'h40);
    check("pre_rst_flush", 32'(bus.Flush), 32'd1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit          st, chg, br;
      logic [1:0]  md;
      logic [31:0] tg;
      if ($urandom_range(0, 149) == 0) do_reset();
      st  = ($urandom_range(0, 4) == 0);
      chg = ($urandom_range(0, 1) == 1);
      md  = 2'($urandom_range(0, 3));
      br  = ($urandom_range(0, 1) == 1);
      tg  = ($urandom_range(0, 3) == 0) ? (m_pc + 32'd4) : $urandom;
      cyc(st, chg, md, br, tg);
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
